// File: rtl/fetch_if.sv
// Instruction-memory read port and decode-facing output bundle of the fetch stage.
// master = fetch_stage, slave = BRAM + decode side.
interface fetch_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned IWIDTH     = 32
);
    logic                  imem_en_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic [IWIDTH-1:0]     imem_rdata_i;
    logic                  valid_o;
    logic [IWIDTH-1:0]     instr_o;
    logic [ADDR_WIDTH-1:0] pc_o;

    modport master (
        output imem_en_o, imem_addr_o, valid_o, instr_o, pc_o,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_en_o, imem_addr_o, valid_o, instr_o, pc_o,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_stage.sv
// BRISKI instruction-fetch front end: owns the PC, issues BRAM reads and carries
// each instruction with its PC through N = popcount(FETCH_STAGES) stages.
module fetch_stage #(
    parameter int unsigned           BRISKI_MEM_DEPTH = 1024,
    parameter int unsigned           ADDR_WIDTH       = $clog2(BRISKI_MEM_DEPTH),
    parameter int unsigned           IWIDTH           = 32,
    parameter logic [ADDR_WIDTH-1:0] STARTUP_ADDR     = '0,
    parameter logic [4:0]            FETCH_STAGES     = 5'b00001
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  stall_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
    fetch_if.master               fetch
);

    function automatic int unsigned popcount(input logic [4:0] mask);
        int unsigned cnt = 0;
        for (int unsigned i = 0; i < 5; i++) cnt += 32'(mask[i]);
        return cnt;
    endfunction

    localparam int unsigned N = popcount(FETCH_STAGES);

    logic                  pc_q;
    logic [ADDR_WIDTH-1:0] pc_addr_q;
    logic                  v0_q;
    logic [ADDR_WIDTH-1:0] pc0_q;
    logic                  issue;

    assign issue             = ~stall_i & reset_n;
    assign fetch.imem_en_o   = issue;
    assign fetch.imem_addr_o = pc_addr_q;
    assign pc_q              = 1'b0;

    // Redirect wins over both issue and stall; the old-PC read of that cycle is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_addr_q <= STARTUP_ADDR;
            v0_q      <= 1'b0;
            pc0_q     <= '0;
        end else begin
            if (redirect_valid_i)
                pc_addr_q <= redirect_addr_i;
            else if (issue)
                pc_addr_q <= pc_addr_q + 1'b1;

            if (!stall_i)
                pc0_q <= pc_addr_q;

            if (redirect_valid_i)
                v0_q <= 1'b0;
            else if (!stall_i)
                v0_q <= 1'b1;
        end
    end

    generate
        if (N == 1) begin : g_bram_out
            assign fetch.valid_o = v0_q;
            assign fetch.pc_o    = pc0_q;
            assign fetch.instr_o = fetch.imem_rdata_i;
        end else begin : g_out_regs
            logic                  v_q     [1:N-1];
            logic [ADDR_WIDTH-1:0] pc_s    [1:N-1];
            logic [IWIDTH-1:0]     instr_q [1:N-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 1; i < N; i++) begin
                        v_q[i]     <= 1'b0;
                        pc_s[i]    <= '0;
                        instr_q[i] <= '0;
                    end
                end else begin
                    if (!stall_i) begin
                        v_q[1]     <= v0_q;
                        pc_s[1]    <= pc0_q;
                        instr_q[1] <= fetch.imem_rdata_i;
                        for (int unsigned i = 2; i < N; i++) begin
                            v_q[i]     <= v_q[i-1];
                            pc_s[i]    <= pc_s[i-1];
                            instr_q[i] <= instr_q[i-1];
                        end
                    end
                    if (redirect_valid_i) begin
                        for (int unsigned i = 1; i < N; i++) v_q[i] <= 1'b0;
                    end
                end
            end

            assign fetch.valid_o = v_q[N-1];
            assign fetch.pc_o    = pc_s[N-1];
            assign fetch.instr_o = instr_q[N-1];
        end
    endgenerate

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: three depths (N=1,2,3) share one stimulus stream and are
// checked each cycle against a history-based model of the fetch rules.
module tb_fetch_stage;
    localparam int unsigned AW   = 8;
    localparam int unsigned IW   = 32;
    localparam int          MAXC = 1024;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stall_i;
    logic          redirect_valid_i;
    logic [AW-1:0] redirect_addr_i;

    always #5 clk = ~clk;

    fetch_if #(.ADDR_WIDTH(AW), .IWIDTH(IW)) bus1 ();
    fetch_if #(.ADDR_WIDTH(AW), .IWIDTH(IW)) bus2 ();
    fetch_if #(.ADDR_WIDTH(AW), .IWIDTH(IW)) bus3 ();

    fetch_stage #(.ADDR_WIDTH(AW), .IWIDTH(IW), .STARTUP_ADDR(8'h00), .FETCH_STAGES(5'b00001)) dut1 (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .redirect_valid_i(redirect_valid_i),
        .redirect_addr_i(redirect_addr_i), .fetch(bus1));
    fetch_stage #(.ADDR_WIDTH(AW), .IWIDTH(IW), .STARTUP_ADDR(8'h00), .FETCH_STAGES(5'b01001)) dut2 (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .redirect_valid_i(redirect_valid_i),
        .redirect_addr_i(redirect_addr_i), .fetch(bus2));
    fetch_stage #(.ADDR_WIDTH(AW), .IWIDTH(IW), .STARTUP_ADDR(8'h00), .FETCH_STAGES(5'b00111)) dut3 (
        .clk(clk), .reset_n(reset_n), .stall_i(stall_i), .redirect_valid_i(redirect_valid_i),
        .redirect_addr_i(redirect_addr_i), .fetch(bus3));

    // BRAM models: word i holds 0x1000+i; output holds while enable is low.
    initial begin
        bus1.imem_rdata_i = '0;
        bus2.imem_rdata_i = '0;
        bus3.imem_rdata_i = '0;
    end
    always @(posedge clk) if (bus1.imem_en_o) bus1.imem_rdata_i <= 32'h1000 + 32'(bus1.imem_addr_o);
    always @(posedge clk) if (bus2.imem_en_o) bus2.imem_rdata_i <= 32'h1000 + 32'(bus2.imem_addr_o);
    always @(posedge clk) if (bus3.imem_en_o) bus3.imem_rdata_i <= 32'h1000 + 32'(bus3.imem_addr_o);

    // Per-cycle history of inputs and of the architectural PC.
    bit            rst_h   [MAXC];
    bit            stall_h [MAXC];
    bit            redir_h [MAXC];
    logic [AW-1:0] raddr_h [MAXC];
    logic [AW-1:0] pc_h    [MAXC];
    int            cyc_n  = 0;
    int            errors = 0;
    int            checks = 0;

    // An instruction is on the outputs in cycle c when it was issued in the cycle that is
    // the n-th unstalled cycle looking back, with no reset or redirect anywhere since.
    function automatic void expect_out(input int c, input int n, output logic v, output logic [AW-1:0] p);
        int k = 0;
        v = 1'b0;
        p = '0;
        if (!rst_h[c]) return;
        for (int j = c - 1; j >= 0; j--) begin
            if (!rst_h[j] || redir_h[j]) return;
            if (!stall_h[j]) begin
                k++;
                if (k == n) begin
                    v = 1'b1;
                    p = pc_h[j];
                    return;
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_n, obs, exp_v);
        end
    endtask

    task automatic chk_dut(input string nm, input int n, input logic en, input logic [AW-1:0] addr,
                           input logic v, input logic [AW-1:0] p, input logic [IW-1:0] ins);
        logic          ev;
        logic [AW-1:0] ep;
        expect_out(cyc_n, n, ev, ep);
        chk({nm, ".imem_en"}, 32'(en), 32'(rst_h[cyc_n] && !stall_h[cyc_n]));
        chk({nm, ".imem_addr"}, 32'(addr), 32'(pc_h[cyc_n]));
        chk({nm, ".valid"}, 32'(v), 32'(ev));
        if (ev) begin
            chk({nm, ".pc"}, 32'(p), 32'(ep));
            chk({nm, ".instr"}, ins, 32'h1000 + 32'(ep));
        end else if (!rst_h[cyc_n]) begin
            chk({nm, ".rst_pc"}, 32'(p), 32'h0);
            if (n > 1) chk({nm, ".rst_instr"}, ins, 32'h0);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge, check at the falling edge.
    task automatic step(input logic rn, input logic s, input logic r, input logic [AW-1:0] a);
        reset_n          = rn;
        stall_i          = s;
        redirect_valid_i = r;
        redirect_addr_i  = a;
        rst_h[cyc_n]     = rn;
        stall_h[cyc_n]   = s;
        redir_h[cyc_n]   = r;
        raddr_h[cyc_n]   = a;
        if (!rn || cyc_n == 0 || !rst_h[cyc_n-1])
            pc_h[cyc_n] = 8'h00;
        else if (redir_h[cyc_n-1])
            pc_h[cyc_n] = raddr_h[cyc_n-1];
        else if (!stall_h[cyc_n-1])
            pc_h[cyc_n] = pc_h[cyc_n-1] + 8'd1;
        else
            pc_h[cyc_n] = pc_h[cyc_n-1];
        @(negedge clk);
        chk_dut("n1", 1, bus1.imem_en_o, bus1.imem_addr_o, bus1.valid_o, bus1.pc_o, bus1.instr_o);
        chk_dut("n2", 2, bus2.imem_en_o, bus2.imem_addr_o, bus2.valid_o, bus2.pc_o, bus2.instr_o);
        chk_dut("n3", 3, bus3.imem_en_o, bus3.imem_addr_o, bus3.valid_o, bus3.pc_o, bus3.instr_o);
        @(posedge clk);
        #1;
        if (cyc_n < MAXC - 1) cyc_n++;
    endtask

    initial begin
        reset_n          = 1'b1;
        stall_i          = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_addr_i  = '0;
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

        step(1'b1, 1'b0, 1'b1, 8'h40);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 1'b1, 8'h20);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

        step(1'b1, 1'b0, 1'b1, 8'hFD);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

        step(1'b1, 1'b0, 1'b1, 8'h10);
        step(1'b1, 1'b0, 1'b1, 8'h30);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 300; i++)
            step(1'b1, ($urandom_range(3) == 0), ($urandom_range(11) == 0), 8'($urandom));

        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
